uart_reg_responder: RTL and testbench
=====================================

# uart_reg_responder

Byte-level command responder that sits on the byte side of the UART block. It consumes received bytes (`o_Rx_DV`/`o_Rx_Byte` of the UART) and drives transmit requests back (`i_Tx_DV`/`i_Tx_Byte`). A remote initiator can use it to write and read a bank of eight 8-bit control registers. Each command gets exactly one response byte: ACK, read data, or NAK.

## Interface
- `TIMEOUT_CLKS`, default 3480: clocks allowed between a write-command byte and its data byte before the write is aborted (4 byte-times at 87 clks/bit).
- `i_Clock` in 1: system clock, same clock as the UART.
- `i_Rst_L` in 1: reset, asynchronous, active-low.
- `i_Rx_DV` in 1: one-cycle pulse, received byte valid.
- `i_Rx_Byte` in 8: received byte, sampled when `i_Rx_DV`=1.
- `o_Tx_DV` out 1: one-cycle pulse requesting transmission of `o_Tx_Byte`.
- `o_Tx_Byte` out 8: response byte, held stable from the `o_Tx_DV` pulse until `i_Tx_Done`.
- `i_Tx_Active` in 1: transmitter busy.
- `i_Tx_Done` in 1: one-cycle pulse, transmission finished.
- `o_Regs` out 64: register bank, reg k = bits [8k+7:8k].
- `o_Busy` out 1: high in any state other than IDLE.
- `o_Overrun` out 1: sticky; set when a received byte is dropped; cleared only by reset.

## Operation
- Command byte format:
  - bit7 = 1 means write, 0 means read.
  - bits[6:3] must be 0000; any other value makes the command invalid.
  - bits[2:0] = register address.
- Response bytes: ACK = 0x06, NAK = 0x15.
- States and transitions:
  - IDLE: waits for `i_Rx_DV`.
    - Valid read: latch `o_Tx_Byte` = reg[addr], go to SEND.
    - Valid write: latch addr, clear the timeout counter, go to WAIT_DATA.
    - Invalid command: `o_Tx_Byte` = 0x15, go to SEND.
  - WAIT_DATA:
    - On `i_Rx_DV`: reg[addr] <= `i_Rx_Byte`, `o_Tx_Byte` = 0x06, go to SEND.
    - Otherwise the counter increments each cycle. When it reaches `TIMEOUT_CLKS`-1 with no byte, `o_Tx_Byte` = 0x15, no register change, go to SEND.
  - SEND:
    - If `i_Tx_Active`=0, pulse `o_Tx_DV` for one cycle and go to WAIT_DONE.
    - Otherwise hold in SEND.
  - WAIT_DONE: on `i_Tx_Done`, go to IDLE.
- `i_Rx_DV` in SEND or WAIT_DONE: the byte is dropped and `o_Overrun` is set to 1. The FSM is unaffected.
- Register bank is write-only through the write command and read through the read command. No other writers.

## Timing
- Reset values: `o_Tx_DV`=0, `o_Tx_Byte`=0x00, `o_Regs`=0, `o_Busy`=0, `o_Overrun`=0, state IDLE, timeout counter 0. Reset asserted mid-transaction aborts immediately; no response is sent.
- All outputs are registered.
- Read, with the transmitter idle: `i_Rx_DV` sampled at edge N. SEND is entered at N. `o_Tx_DV`=1 in cycle N+1 to N+2 with valid `o_Tx_Byte`. That is a one-cycle latency from command to request.
- Write: the data byte is sampled at edge N. `o_Regs` updates at edge N; the new value is visible in cycle N+1. `o_Tx_DV`=1 in cycle N+1 with byte 0x06.
- A read issued immediately after a write to the same address returns the new value.
- `o_Tx_DV` is never asserted while `i_Tx_Active`=1. It is exactly one cycle wide, and there is exactly one pulse per command.
- Timeout boundary:
  - `i_Rx_DV` in the same cycle the counter reaches `TIMEOUT_CLKS`-1: the byte wins and the write completes with ACK.
  - A byte arriving at count `TIMEOUT_CLKS` or later: the write has already aborted. That byte goes to SEND/WAIT_DONE and is dropped (overrun set).
- `i_Tx_Done` and `i_Rx_DV` in the same cycle in WAIT_DONE: the byte is dropped and overrun is set. IDLE is reached at the next edge.
- Counter width: clog2(`TIMEOUT_CLKS`). The counter must not wrap.
- `o_Busy` = (state != IDLE), registered with the state.

## Test plan
- Write then read: send 0x83 then 0xA5.
  - Response: `o_Tx_Byte`=0x06 with one `o_Tx_DV` pulse.
  - `o_Regs[31:24]`=0xA5.
  - Then send 0x03: response 0xA5.
- Invalid command: send 0x48.
  - Response: 0x15.
  - `o_Regs` unchanged; FSM back in IDLE after `i_Tx_Done`.
- Write timeout: send 0x81 and then nothing for `TIMEOUT_CLKS` cycles.
  - Response: 0x15.
  - `o_Regs[15:8]` stays 0x00.
  - Repeat with the data byte at count `TIMEOUT_CLKS`-1: ACK, register written.
- Transmitter busy: hold `i_Tx_Active`=1 and send read 0x00.
  - No `o_Tx_DV` while active.
  - Pulse occurs one cycle after `i_Tx_Active` falls, with byte 0x00.
- Overrun: while in WAIT_DONE, inject an `i_Rx_DV` with byte 0x07.
  - `o_Overrun`=1 and stays 1.
  - No second response is sent.
  - The next command after IDLE works normally.
- Reset mid-operation: after write command 0x82, drop `i_Rst_L` asynchronously between clock edges.
  - All outputs return to their reset values immediately.
  - A following read of 0x02 returns 0x00.

Source files
------------

// File: rtl/uart_reg_responder_if.sv
//==============================================================================
// uart_reg_responder_if : byte handshake between the UART and the responder
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

interface uart_reg_responder_if;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done;

  // slave = responder side, master = UART side
  modport slave (
    input  i_Rx_DV,
    input  i_Rx_Byte,
    input  i_Tx_Active,
    input  i_Tx_Done,
    output o_Tx_DV,
    output o_Tx_Byte
  );

  modport master (
    output i_Rx_DV,
    output i_Rx_Byte,
    output i_Tx_Active,
    output i_Tx_Done,
    input  o_Tx_DV,
    input  o_Tx_Byte
  );
endinterface

`default_nettype wire

// File: rtl/uart_reg_responder.sv
//==============================================================================
// uart_reg_responder : UART byte command responder for eight 8-bit registers
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_reg_responder #(
  parameter int TIMEOUT_CLKS = 3480
) (
  input  wire logic                i_Clock,
  input  wire logic                i_Rst_L,
  uart_reg_responder_if.slave      bus,
  output logic [63:0]              o_Regs,
  output logic                     o_Busy,
  output logic                     o_Overrun
);

  localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       addr_q, addr_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_dv_q, tx_dv_d;
  logic [63:0]      regs_q, regs_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    tx_byte_d = tx_byte_q;
    tx_dv_d   = 1'b0;
    regs_d    = regs_q;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_Rx_DV) begin
          if (bus.i_Rx_Byte[6:3] != 4'b0000) begin
            tx_byte_d = NAK;
            state_d   = ST_SEND;
          end else if (bus.i_Rx_Byte[7]) begin
            addr_d  = bus.i_Rx_Byte[2:0];
            cnt_d   = '0;
            state_d = ST_WAIT_DATA;
          end else begin
            tx_byte_d = regs_q[{bus.i_Rx_Byte[2:0], 3'b000} +: 8];
            state_d   = ST_SEND;
          end
        end
      end

      ST_WAIT_DATA: begin
        // A byte arriving on the last counted cycle still completes the write
        if (bus.i_Rx_DV) begin
          regs_d[{addr_q, 3'b000} +: 8] = bus.i_Rx_Byte;
          tx_byte_d = ACK;
          state_d   = ST_SEND;
        end else if (cnt_q == CNT_LAST) begin
          tx_byte_d = NAK;
          state_d   = ST_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SEND: begin
        if (bus.i_Rx_DV) overrun_d = 1'b1;
        if (!bus.i_Tx_Active) begin
          tx_dv_d = 1'b1;
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (bus.i_Rx_DV) overrun_d = 1'b1;
        if (bus.i_Tx_Done) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= 3'd0;
      tx_byte_q <= 8'h00;
      tx_dv_q   <= 1'b0;
      regs_q    <= 64'd0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      tx_byte_q <= tx_byte_d;
      tx_dv_q   <= tx_dv_d;
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.o_Tx_DV   = tx_dv_q;
  assign bus.o_Tx_Byte = tx_byte_q;
  assign o_Regs        = regs_q;
  assign o_Busy        = busy_q;
  assign o_Overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_reg_responder.sv
//==============================================================================
// tb_uart_reg_responder : directed + randomized bench with a register-bank model
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_reg_responder;

  localparam int T = 20;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clk;
  logic        rst_n;
  logic [63:0] o_Regs;
  logic        o_Busy;
  logic        o_Overrun;

  uart_reg_responder_if bif ();

  uart_reg_responder #(.TIMEOUT_CLKS(T)) dut (
    .i_Clock   (clk),
    .i_Rst_L   (rst_n),
    .bus       (bif),
    .o_Regs    (o_Regs),
    .o_Busy    (o_Busy),
    .o_Overrun (o_Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model [8];
  logic       ovr_model;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_model();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = model[k];
    return v;
  endfunction

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    bif.i_Rx_DV   = 1'b1;
    bif.i_Rx_Byte = b;
    @(negedge clk);
    bif.i_Rx_DV   = 1'b0;
  endtask

  // gap: <0 no data byte (timeout), 0..T-1 falling edges before data, T = late byte
  // busy: falling edges with the transmitter held busy; inj: 1 byte in WAIT_DONE, 2 byte with Tx_Done
  task automatic transact(input logic [7:0] cmd, input int gap, input logic [7:0] data,
                          input int busy, input int inj);
    logic [7:0] exp_b;
    int         exp_lat;
    int         lat;
    bit         is_wr;
    is_wr   = (cmd[6:3] == 4'd0) && cmd[7];
    exp_lat = 1;
    if (cmd[6:3] != 4'd0)  exp_b = NAK;
    else if (!cmd[7])      exp_b = model[cmd[2:0]];
    else if (gap < 0) begin
      exp_b   = NAK;
      exp_lat = T + 1;
    end else if (gap >= T) begin
      exp_b     = NAK;
      exp_lat   = 0;
      ovr_model = 1'b1;
    end else begin
      exp_b = ACK;
      model[cmd[2:0]] = data;
    end

    if (busy > 0) bif.i_Tx_Active = 1'b1;
    send_byte(cmd);
    if (is_wr && gap >= 0) begin
      chk("busy_wait_data", 64'(o_Busy), 64'd1);
      repeat (gap) @(negedge clk);
      send_byte(data);
    end
    if (busy > 0) begin
      repeat (busy) begin
        @(negedge clk);
        chk("no_dv_while_active", 64'(bif.o_Tx_DV), 64'd0);
      end
      bif.i_Tx_Active = 1'b0;
    end

    lat = 0;
    while (bif.o_Tx_DV !== 1'b1 && lat < T + 20) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_latency", 64'(lat), 64'(exp_lat));
    chk("resp_byte", 64'(bif.o_Tx_Byte), 64'(exp_b));
    chk("regs", o_Regs, pack_model());

    @(negedge clk);
    chk("dv_width", 64'(bif.o_Tx_DV), 64'd0);
    bif.i_Tx_Active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (inj == 1 && i == 1) begin
        bif.i_Rx_DV   = 1'b1;
        bif.i_Rx_Byte = 8'h07;
      end
      @(negedge clk);
      bif.i_Rx_DV = 1'b0;
      chk("byte_hold", 64'(bif.o_Tx_Byte), 64'(exp_b));
      chk("no_second_dv", 64'(bif.o_Tx_DV), 64'd0);
    end
    bif.i_Tx_Done   = 1'b1;
    bif.i_Tx_Active = 1'b0;
    if (inj == 2) begin
      bif.i_Rx_DV   = 1'b1;
      bif.i_Rx_Byte = 8'h07;
    end
    @(negedge clk);
    bif.i_Tx_Done = 1'b0;
    bif.i_Rx_DV   = 1'b0;
    if (inj != 0) ovr_model = 1'b1;
    chk("idle_after_done", 64'(o_Busy), 64'd0);
    chk("no_dv_after_done", 64'(bif.o_Tx_DV), 64'd0);
    chk("overrun", 64'(o_Overrun), 64'(ovr_model));
    chk("regs_after_done", o_Regs, pack_model());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmd;
    logic [7:0] d;
    int         kind;
    int         gap;
    int         busy;

    bif.i_Rx_DV     = 1'b0;
    bif.i_Rx_Byte   = 8'h00;
    bif.i_Tx_Active = 1'b0;
    bif.i_Tx_Done   = 1'b0;
    rst_n           = 1'b0;
    for (int k = 0; k < 8; k++) model[k] = 8'h00;
    ovr_model = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_tx_dv", 64'(bif.o_Tx_DV), 64'd0);
    chk("rst_tx_byte", 64'(bif.o_Tx_Byte), 64'd0);
    chk("rst_regs", o_Regs, 64'd0);
    chk("rst_busy", 64'(o_Busy), 64'd0);
    chk("rst_overrun", 64'(o_Overrun), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write then read back the same register
    transact(8'h83, 0, 8'hA5, 0, 0);
    chk("reg3_written", 64'(o_Regs[31:24]), 64'hA5);
    transact(8'h03, -1, 8'h00, 0, 0);

    // Invalid command
    transact(8'h48, -1, 8'h00, 0, 0);

    // Write timeout, then data on the last allowed cycle
    transact(8'h81, -1, 8'h00, 0, 0);
    chk("reg1_untouched", 64'(o_Regs[15:8]), 64'h00);
    transact(8'h81, T - 1, 8'h5A, 0, 0);
    chk("reg1_boundary", 64'(o_Regs[15:8]), 64'h5A);

    // Transmitter busy
    transact(8'h00, -1, 8'h00, 4, 0);

    // Overrun in WAIT_DONE, then late data byte, then byte with Tx_Done
    transact(8'h01, -1, 8'h00, 0, 1);
    transact(8'h81, T, 8'h3C, 0, 0);
    transact(8'h03, -1, 8'h00, 0, 2);
    transact(8'h01, -1, 8'h00, 2, 0);

    // Reset mid-operation
    transact(8'h82, 0, 8'hC3, 0, 0);
    send_byte(8'h82);
    chk("busy_before_reset", 64'(o_Busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) model[k] = 8'h00;
    ovr_model = 1'b0;
    chk("async_rst_tx_dv", 64'(bif.o_Tx_DV), 64'd0);
    chk("async_rst_tx_byte", 64'(bif.o_Tx_Byte), 64'd0);
    chk("async_rst_regs", o_Regs, 64'd0);
    chk("async_rst_busy", 64'(o_Busy), 64'd0);
    chk("async_rst_overrun", 64'(o_Overrun), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    transact(8'h02, -1, 8'h00, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      d    = 8'($urandom);
      gap  = -1;
      busy = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0;
      if (kind < 2) begin
        cmd = 8'($urandom);
        if (cmd[6:3] == 4'd0) cmd[3] = 1'b1;
      end else if (kind < 6) begin
        cmd = {5'b00000, 3'($urandom)};
      end else begin
        cmd = {5'b10000, 3'($urandom)};
        if ($urandom_range(0, 7) == 0) busy = 0;
        else gap = int'($urandom_range(0, T - 1));
      end
      transact(cmd, gap, d, busy, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
